rho_arbiter: RTL and testbench

Round-robin arbiter that shares one instance of the SWAN64 `rho` linear layer between two requesters. Each requester is typically a round engine processing one Feistel side. The arbiter accepts one SIDE_SIZE-bit word per cycle over valid/ready handshakes and applies `rho` combinationally. The result is registered, tagged with the requester ID, and returned on a single response channel with backpressure. It sits between the round datapaths and the shared diffusion layer, so the design needs only one `rho` instance.

---
 rtl/rho_arbiter.sv | 94 +++++++++
 tb/tb_rho_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/rho_arbiter.sv
// Two-requester round-robin front end for one shared rho diffusion layer.
// Latency: 1 cycle. Backpressure: both readys drop while a held response is unaccepted.
module rho_arbiter #(
    parameter int BLOCK_SIZE = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic [0:BLOCK_SIZE/2-1] req0_data,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [0:BLOCK_SIZE/2-1] req1_data,
    output logic                 req1_ready,
    output logic                 rsp_valid,
    output logic [0:BLOCK_SIZE/2-1] rsp_data,
    output logic                 rsp_id,
    input  logic                 rsp_ready,
    output logic [15:0]          served0,
    output logic [15:0]          served1
);
    localparam int SIDE_SIZE = BLOCK_SIZE / 2;
    localparam int CW        = SIDE_SIZE / 4;

    // Each column is XORed with the parity of all four columns.
    function automatic logic [0:SIDE_SIZE-1] rho(input logic [0:SIDE_SIZE-1] w);
        logic [CW-1:0]          t;
        logic [0:SIDE_SIZE-1]   r;
        t = '0;
        for (int k = 0; k < 4; k++) t = t ^ w[k*CW +: CW];
        r = '0;
        for (int k = 0; k < 4; k++) r[k*CW +: CW] = w[k*CW +: CW] ^ t;
        return r;
    endfunction

    logic                 rsp_valid_q, rsp_valid_d;
    logic [0:SIDE_SIZE-1] rsp_data_q, rsp_data_d;
    logic                 rsp_id_q, rsp_id_d;
    logic                 last_q, last_d;
    logic [15:0]          served0_q, served0_d;
    logic [15:0]          served1_q, served1_d;

    logic can_accept, gnt_vld, gnt_id, xfer;

    always_comb begin
        can_accept = (!rsp_valid_q || rsp_ready) && !rst;
        gnt_vld    = req0_valid || req1_valid;
        gnt_id     = (req0_valid && req1_valid) ? ~last_q : req1_valid;
        xfer       = can_accept && gnt_vld;
        req0_ready = xfer && !gnt_id;
        req1_ready = xfer && gnt_id;

        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        last_d      = last_q;
        served0_d   = served0_q;
        served1_d   = served1_q;

        if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;
        if (xfer) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = rho(gnt_id ? req1_data : req0_data);
            rsp_id_d    = gnt_id;
            last_d      = gnt_id;
            if (gnt_id) served1_d = served1_q + 16'd1;
            else        served0_d = served0_q + 16'd1;
        end
    end

    // last resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
            last_q      <= 1'b1;
            served0_q   <= '0;
            served1_q   <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            last_q      <= last_d;
            served0_q   <= served0_d;
            served1_q   <= served1_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign served0   = served0_q;
    assign served1   = served1_q;
endmodule

// File: tb/tb_rho_arbiter.sv
// Directed bench for rho_arbiter with hand-computed rho results.
module tb_rho_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [0:31] req0_data, req1_data, rsp_data;
    logic        rsp_valid, rsp_id, rsp_ready;
    logic [15:0] served0, served1;

    int tests = 0;
    int fails = 0;

    rho_arbiter #(.BLOCK_SIZE(64)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .rsp_ready(rsp_ready), .served0(served0), .served1(served1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        logic [31:0] held;
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0; req0_data = '0; req1_data = '0; rsp_ready = 0;
        step(); step();
        chk("reset_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_data", rsp_data, 32'd0);
        chk("reset_id", {31'd0, rsp_id}, 32'd0);
        chk("reset_served0", {16'd0, served0}, 32'd0);
        chk("reset_served1", {16'd0, served1}, 32'd0);
        rst = 1'b0;
        #1;

        // Single requester
        req0_valid = 1; req0_data = 32'h01020408; rsp_ready = 1;
        #1;
        chk("t1_rdy0", {31'd0, req0_ready}, 32'd1);
        chk("t1_rdy1", {31'd0, req1_ready}, 32'd0);
        step();
        chk("t1_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t1_data", rsp_data, 32'h0E0D0B07);
        chk("t1_id", {31'd0, rsp_id}, 32'd0);
        chk("t1_served0", {16'd0, served0}, 32'd1);
        req0_valid = 0;
        step();
        chk("t1_drain", {31'd0, rsp_valid}, 32'd0);

        // Continuous tie from reset: grants alternate starting with 0
        do_reset();
        req0_valid = 1; req0_data = 32'h12345678;
        req1_valid = 1; req1_data = 32'h01000000; rsp_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_rdy0", {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("t2_rdy1", {31'd0, req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
            step();
            chk("t2_valid", {31'd0, rsp_valid}, 32'd1);
            chk("t2_data", rsp_data, (i % 2 == 0) ? 32'h1A3C5E70 : 32'h00010101);
            chk("t2_id", {31'd0, rsp_id}, (i % 2 == 0) ? 32'd0 : 32'd1);
        end
        chk("t2_served0", {16'd0, served0}, 32'd2);
        chk("t2_served1", {16'd0, served1}, 32'd2);

        // Backpressure: drain first, then accept one and stall
        req0_valid = 0; req1_valid = 0;
        step();
        chk("t3_empty", {31'd0, rsp_valid}, 32'd0);
        req0_valid = 1; req1_valid = 1; rsp_ready = 0;
        #1;
        chk("t3_rdy0_first", {31'd0, req0_ready}, 32'd1);
        step();
        chk("t3_data", rsp_data, 32'h1A3C5E70);
        chk("t3_served0", {16'd0, served0}, 32'd3);
        held = rsp_data;
        for (int i = 0; i < 5; i++) begin
            chk("t3_stall_rdy", {30'd0, req0_ready, req1_ready}, 32'd0);
            step();
            chk("t3_stall_valid", {31'd0, rsp_valid}, 32'd1);
            chk("t3_stall_data", rsp_data, held);
            chk("t3_stall_id", {31'd0, rsp_id}, 32'd0);
            chk("t3_stall_served", {served0, served1}, {16'd3, 16'd2});
        end
        rsp_ready = 1;
        #1;
        chk("t3_reload_rdy1", {31'd0, req1_ready}, 32'd1);
        chk("t3_reload_rdy0", {31'd0, req0_ready}, 32'd0);
        step();
        chk("t3_reload_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t3_reload_data", rsp_data, 32'h00010101);
        chk("t3_reload_id", {31'd0, rsp_id}, 32'd1);
        chk("t3_served1", {16'd0, served1}, 32'd3);

        // Parity-zero words pass through unchanged
        req1_valid = 0; req0_data = 32'hFFFFFFFF;
        step();
        chk("t4_ff", rsp_data, 32'hFFFFFFFF);
        chk("t4_ff_id", {31'd0, rsp_id}, 32'd0);
        req0_valid = 0; req1_valid = 1; req1_data = 32'h11111111;
        step();
        chk("t4_11", rsp_data, 32'h11111111);
        chk("t4_11_id", {31'd0, rsp_id}, 32'd1);

        // Counter wrap on requester 1
        req1_valid = 0;
        do_reset();
        req1_valid = 1; req1_data = 32'hA5A5A5A5; rsp_ready = 1;
        repeat (65535) @(posedge clk);
        #1;
        chk("t5_ffff", {16'd0, served1}, 32'h0000FFFF);
        chk("t5_served0", {16'd0, served0}, 32'd0);
        step();
        chk("t5_wrap", {16'd0, served1}, 32'h00000000);

        // Reset discards a stalled response
        req1_valid = 0; req0_valid = 1; req0_data = 32'h01020408; rsp_ready = 0;
        step();
        chk("t6_pending", {31'd0, rsp_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_async_valid", {31'd0, rsp_valid}, 32'd0);
        chk("t6_async_data", rsp_data, 32'd0);
        step();
        rst = 1'b0;
        req1_valid = 1; rsp_ready = 1;
        #1;
        chk("t6_served0", {16'd0, served0}, 32'd0);
        chk("t6_tie_rdy0", {31'd0, req0_ready}, 32'd1);
        chk("t6_tie_rdy1", {31'd0, req1_ready}, 32'd0);
        step();
        chk("t6_id", {31'd0, rsp_id}, 32'd0);
        chk("t6_data", rsp_data, 32'h0E0D0B07);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
